// File: rtl/afifo_pkg.sv
// Shared defaults and lane helpers for the async-FIFO read-side byte packer.
package afifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LANES_DEF  = 4;

  // Lane-valid mask for a partial word holding cnt bytes; callers truncate to LANES.
  function automatic logic [31:0] keep_from_cnt(input int unsigned cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction

  function automatic logic lane_kept(input int unsigned lane, input int unsigned cnt);
    return lane < cnt;
  endfunction

endpackage

// File: rtl/afifo_rd_tmo.sv
// Idle-timeout counter: counts no-pop cycles while a partial word is held.
module afifo_rd_tmo #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic pop,
  input  logic clear,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned W = $clog2(TIMEOUT + 1);
    logic [W-1:0] tmo;

    assign expire = active & !pop & !clear & (tmo == W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tmo <= '0;
      end else if (clear | pop | !active | expire) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_rd_packer.sv
// Drains the async FIFO read port and packs LANES bytes per output word,
// flushing partial words on idle timeout or explicit request.
module afifo_rd_packer
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     rempty,
  input  logic [DATA_W-1:0]        rdata,
  output logic                     rinc,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*LANES-1:0]  out_data,
  output logic [LANES-1:0]         out_keep,
  output logic [15:0]              word_cnt
);

  localparam int unsigned CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]                  cnt;
  logic [DATA_W-1:0]              acc [0:LANES-2];
  logic                           flush_pend;
  logic                           out_free;
  logic                           pop;
  logic                           word_done;
  logic                           do_flush;
  logic                           expire;
  logic [LANES-1:0]               keep_flush;
  logic [DATA_W*(LANES-1)-1:0]    acc_flat;
  logic [DATA_W*LANES-1:0]        acc_masked;

  assign out_free  = !out_valid | out_ready;
  // Pops stall while a flush is pending so the flushed word cannot grow under it.
  assign rinc      = !rrst & !rempty & !(flush_pend & (cnt != '0)) & ((cnt != LAST) | out_free);
  assign pop       = rinc;
  assign word_done = pop & (cnt == LAST);
  assign do_flush  = flush_pend & (cnt != '0) & out_free;
  assign keep_flush = LANES'(keep_from_cnt(32'(cnt)));

  always_comb begin
    acc_flat   = '0;
    acc_masked = '0;
    for (int i = 0; i < int'(LANES) - 1; i++) begin
      acc_flat[i*DATA_W +: DATA_W] = acc[i];
      if (lane_kept(i, 32'(cnt))) begin
        acc_masked[i*DATA_W +: DATA_W] = acc[i];
      end
    end
  end

  afifo_rd_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (rclk),
    .rst    (rrst),
    .active (cnt != '0),
    .pop    (pop),
    .clear  (do_flush),
    .expire (expire)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      word_cnt   <= '0;
      for (int i = 0; i < int'(LANES) - 1; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (out_valid & out_ready) begin
        word_cnt <= word_cnt + 16'd1;
      end

      if (word_done) begin
        out_data   <= {rdata, acc_flat};
        out_keep   <= '1;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else if (do_flush) begin
        out_data   <= acc_masked;
        out_keep   <= keep_flush;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (pop) begin
          acc[cnt] <= rdata;
          cnt      <= cnt + 1'b1;
        end
        if ((flush_req | expire) & (cnt != '0)) begin
          flush_pend <= 1'b1;
        end
      end

      if (word_done | do_flush) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Self-checking bench for afifo_rd_packer: FIFO and word scoreboard modelled with queues.
module tb_afifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rinc;
  logic        flush_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] word_cnt;

  afifo_rd_packer #(.DATA_W(8), .LANES(4), .TIMEOUT(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush_req (flush_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .word_cnt  (word_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] in_bytes;
    bit          use_tmo;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  word_t      exp_q[$];
  logic [7:0] fifo_q[$];
  bit         hold_empty = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_hs_cyc = 0;
  int         pops_run = 0;
  int         max_run = 0;
  int         idle_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic upd_inputs();
    rempty = hold_empty || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    upd_inputs();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.data = d;
    w.keep = k;
    exp_q.push_back(w);
  endtask

  // One clock: sample pop/handshake before the edge, apply them to the models after it.
  task automatic step();
    logic        s_pop, s_hs;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    word_t       e;
    @(negedge rclk);
    s_pop  = rinc & !rempty;
    s_hs   = out_valid & out_ready;
    s_data = out_data;
    s_keep = out_keep;
    @(posedge rclk);
    #1;
    cyc++;
    if (s_pop) begin
      void'(fifo_q.pop_front());
      pops_run++;
      if (pops_run > max_run) max_run = pops_run;
      idle_run = 0;
    end else begin
      pops_run = 0;
      idle_run++;
    end
    if (s_hs) begin
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h keep 0x%0h, required no word", s_data, s_keep);
      end else begin
        e = exp_q.pop_front();
        check("word_data", s_data, e.data);
        check("word_keep", 32'(s_keep), 32'(e.keep));
      end
    end
    upd_inputs();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size() + fifo_q.size()), 32'd0);
  endtask

  task automatic do_reset(input bit check_rst);
    rrst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    hold_empty = 1'b0;
    flush_req  = 1'b0;
    out_ready  = 1'b1;
    upd_inputs();
    repeat (2) @(posedge rclk);
    #1;
    if (check_rst) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_keep", 32'(out_keep), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_rinc", 32'(rinc), 32'd0);
    end
    rrst = 1'b0;
    pops_run = 0;
    idle_run = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [7:0] b;
    int viol, k;

    tbl[0] = '{1, 32'h0000005A, 1'b0, 32'h0000005A, 4'h1};
    tbl[1] = '{2, 32'h0000C3A5, 1'b1, 32'h0000C3A5, 4'h3};
    tbl[2] = '{3, 32'h00FF0080, 1'b0, 32'h00FF0080, 4'h7};
    tbl[3] = '{4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF};
    tbl[4] = '{3, 32'h00010203, 1'b1, 32'h00010203, 4'h7};
    tbl[5] = '{1, 32'h00000000, 1'b0, 32'h00000000, 4'h1};

    // Streaming 1..8 with ready held high.
    do_reset(1'b1);
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    max_run = 0;
    wait_drain("t1_drain", 30);
    check("t1_rinc_run", 32'(max_run), 32'd8);
    check("t1_word_cnt", 32'(word_cnt), 32'd2);

    // Backpressure: first word held, popping stalls at byte 7, then back-to-back.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    repeat (12) step();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data", out_data, 32'h04030201);
    check("t2_keep", 32'(out_keep), 32'hF);
    check("t2_rinc_stall", 32'(rinc), 32'd0);
    check("t2_rempty", 32'(rempty), 32'd0);
    check("t2_bytes_left", 32'(fifo_q.size()), 32'd1);
    repeat (3) step();
    check("t2_hold_data", out_data, 32'h04030201);
    out_ready = 1'b1;
    step();
    k = last_hs_cyc;
    step();
    check("t2_b2b_gap", 32'(last_hs_cyc - k), 32'd1);
    check("t2_word_cnt", 32'(word_cnt), 32'd2);

    // Idle timeout on a 3-byte partial word.
    do_reset(1'b0);
    push(8'h11); push(8'h22); push(8'h33);
    expect_word(32'h00332211, 4'h7);
    repeat (3) step();
    check("t3_popped", 32'(fifo_q.size()), 32'd0);
    repeat (16) step();
    check("t3_valid_early", 32'(out_valid), 32'd0);
    step();
    check("t3_valid_tmo", 32'(out_valid), 32'd1);
    wait_drain("t3_drain", 5);

    // Explicit flush; a byte arriving during the flush starts the next word.
    do_reset(1'b0);
    push(8'hAA); push(8'hBB);
    expect_word(32'h0000BBAA, 4'h3);
    expect_word(32'hFFEEDDCC, 4'hF);
    step(); step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    push(8'hCC);
    check("t4_rinc_blocked", 32'(rinc), 32'd0);
    check("t4_rempty", 32'(rempty), 32'd0);
    step();
    check("t4_flush_valid", 32'(out_valid), 32'd1);
    check("t4_flush_keep", 32'(out_keep), 32'h3);
    step();
    push(8'hDD); push(8'hEE); push(8'hFF);
    wait_drain("t4_drain", 20);

    // Reset mid-word with a pending output word.
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) push(8'(i));
    expect_word(32'h04030201, 4'hF);
    wait_drain("t5_pre_drain", 20);
    check("t5_pre_word_cnt", 32'(word_cnt), 32'd1);
    out_ready = 1'b0;
    for (int i = 9; i <= 14; i++) push(8'(i));
    repeat (8) step();
    push(8'd15);
    #2;
    rrst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_keep", 32'(out_keep), 32'd0);
    check("t5_rst_word_cnt", 32'(word_cnt), 32'd0);
    check("t5_rst_rinc", 32'(rinc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    upd_inputs();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) push(8'(i));
    expect_word(32'h08070605, 4'hF);
    wait_drain("t5_post_drain", 20);

    // Empty FIFO for 100 cycles, including a flush request with nothing held.
    do_reset(1'b0);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      flush_req = (i == 50);
      step();
      if (rinc || out_valid) viol++;
    end
    flush_req = 1'b0;
    check("t6_idle_activity", 32'(viol), 32'd0);
    check("t6_word_cnt", 32'(word_cnt), 32'd0);

    // Table of partial/full words closed by flush, timeout, or completion.
    do_reset(1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < tbl[t].n; j++) push(tbl[t].in_bytes[8*j +: 8]);
      expect_word(tbl[t].exp_data, tbl[t].exp_keep);
      k = 0;
      while (fifo_q.size() != 0 && k < 20) begin
        step();
        k++;
      end
      if (!tbl[t].use_tmo && tbl[t].n < 4) begin
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
      end
      wait_drain("tbl_drain", 40);
    end
    check("tbl_word_cnt", 32'(word_cnt), 32'd6);

    // Random gaps and backpressure against a byte-stream model.
    do_reset(1'b0);
    for (int w = 0; w < 50; w++) begin
      logic [31:0] wd;
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom_range(0, 255));
        wd[8*j +: 8] = b;
        fifo_q.push_back(b);
      end
      expect_word(wd, 4'hF);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      hold_empty = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      if (idle_run >= 6) begin
        hold_empty = 1'b0;
        out_ready  = 1'b1;
      end
      upd_inputs();
      step();
      k++;
    end
    hold_empty = 1'b0;
    out_ready  = 1'b1;
    upd_inputs();
    check("rand_words_left", 32'(exp_q.size()), 32'd0);
    check("rand_word_cnt", 32'(word_cnt), 32'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
